// File: rtl/keypad_matrix_scan.sv
// keypad_matrix_scan
//   Scans a 4x4 mechanical key matrix. One row at a time is driven low. The
//   active-low column lines are read back through a two-flop synchronizer.
//   The first key found in scan order is debounced on press and on release.
//   While that key is tracked, row scanning stops on its row.
//
// Ports
//   clk        scan clock (about 1 kHz, the same clock the display scanner uses)
//   rst_n      asynchronous active-low reset
//   colI[3:0]  column sense lines, active-low (board pull-ups); bit i = column i
//   rowO[3:0]  row drive, one-hot active-low; bit r = row r
//   key_code   {row[1:0], col[1:0]} of the last accepted press; held through release
//   key_valid  one-clock strobe when a press is accepted
//   key_down   high from press acceptance until release acceptance
//   state_dbg  current scanner state (SCAN=0, PRESS_DEB=1, HELD=2, REL_DEB=3)
//
// Handshake: key_valid is a one-clock strobe with no ready/backpressure. The
// consumer must take key_code in the cycle key_valid is high. key_code also
// stays stable until the next accepted press.

module keypad_matrix_scan #(
    parameter int DEB_CNT = 8,   // stable samples to accept press/release, 1..255
    parameter int DWELL   = 4    // clocks per row while scanning, >= 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] colI,
    output logic [3:0] rowO,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_down,
    output logic [1:0] state_dbg
);

    typedef enum logic [1:0] {
        SCAN      = 2'd0,
        PRESS_DEB = 2'd1,
        HELD      = 2'd2,
        REL_DEB   = 2'd3
    } state_t;

    localparam logic [7:0] DEB_LAST = 8'(DEB_CNT);
    localparam logic [7:0] PH_LAST  = 8'(DWELL - 1);

    state_t     state;
    logic [3:0] col_meta;
    logic [3:0] col_s;
    logic [1:0] row;
    logic [1:0] col;
    logic [7:0] phase;
    logic [7:0] cnt;
    logic [1:0] hit_col;

    // Lowest pulled-low column wins when several keys share the row.
    always_comb begin
        hit_col = 2'd3;
        if (!col_s[2]) hit_col = 2'd2;
        if (!col_s[1]) hit_col = 2'd1;
        if (!col_s[0]) hit_col = 2'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col_meta  <= 4'hF;
            col_s     <= 4'hF;
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            phase     <= 8'd0;
            cnt       <= 8'd0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
            key_down  <= 1'b0;
        end else begin
            col_meta  <= colI;
            col_s     <= col_meta;
            key_valid <= 1'b0;

            case (state)
                SCAN: begin
                    if (phase != PH_LAST) begin
                        phase <= phase + 8'd1;
                    end else if (col_s == 4'hF) begin
                        row   <= row + 2'd1;
                        phase <= 8'd0;
                    end else begin
                        col <= hit_col;
                        cnt <= 8'd1;
                        // The scan sample counts as the first stable sample, so with
                        // DEB_CNT=1 the press is accepted on this clock.
                        if (DEB_LAST == 8'd1) begin
                            key_code  <= {row, hit_col};
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            state     <= HELD;
                        end else begin
                            state <= PRESS_DEB;
                        end
                    end
                end

                PRESS_DEB: begin
                    if (!col_s[col]) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == DEB_LAST) begin
                            key_code  <= {row, col};
                            key_valid <= 1'b1;
                            key_down  <= 1'b1;
                            state     <= HELD;
                        end
                    end else begin
                        // The press bounced away. Continue scanning from the next row.
                        state <= SCAN;
                        row   <= row + 2'd1;
                        phase <= 8'd0;
                    end
                end

                HELD: begin
                    // Only the tracked column matters. Other keys are ignored.
                    if (col_s[col]) begin
                        cnt <= 8'd1;
                        if (DEB_LAST == 8'd1) begin
                            key_down <= 1'b0;
                            state    <= SCAN;
                            row      <= row + 2'd1;
                            phase    <= 8'd0;
                        end else begin
                            state <= REL_DEB;
                        end
                    end
                end

                REL_DEB: begin
                    if (col_s[col]) begin
                        cnt <= cnt + 8'd1;
                        if (cnt + 8'd1 == DEB_LAST) begin
                            key_down <= 1'b0;
                            state    <= SCAN;
                            row      <= row + 2'd1;
                            phase    <= 8'd0;
                        end
                    end else begin
                        state <= HELD;
                    end
                end

                default: state <= SCAN;
            endcase
        end
    end

    assign rowO      = ~(4'b0001 << row);
    assign state_dbg = state;

endmodule

// File: tb/tb_keypad_matrix_scan.sv
// tb_keypad_matrix_scan
//   Drives keypad_matrix_scan from a simple switch-matrix model. A column reads
//   low when a pressed key sits on the currently driven row. A reference model
//   tracks scanning and debouncing at the level of rows, dwell counts and
//   stable-sample runs. It is compared with the DUT on every falling edge.
//   Directed scenarios add hand-computed literal expectations.

module tb_keypad_matrix_scan;

    localparam int DEB = 4;
    localparam int DW  = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [3:0]  colI;
    logic [3:0]  rowO;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_down;
    logic [1:0]  state_dbg;
    logic [15:0] keys = 16'h0;   // bit {row,col} = key pressed

    int n_pass  = 0;
    int n_total = 0;
    int n_valid = 0;

    always #5 clk = ~clk;

    keypad_matrix_scan #(.DEB_CNT(DEB), .DWELL(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .colI      (colI),
        .rowO      (rowO),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_down  (key_down),
        .state_dbg (state_dbg)
    );

    // Physical matrix: a pressed key shorts its column to its row line.
    always_comb begin
        colI = 4'hF;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (keys[r*4+c] && !rowO[r]) colI[c] = 1'b0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model ----------------
    // mode: 0 scanning, 1 confirming a press, 2 key held, 3 confirming a release
    int         m_mode, m_row, m_phase, m_cnt, m_col;
    logic [3:0] m_p1, m_p2;
    logic [3:0] e_code;
    logic       e_valid, e_down;

    function automatic int lowest_zero(input logic [3:0] v);
        for (int i = 0; i < 4; i++) if (!v[i]) return i;
        return 0;
    endfunction

    function automatic logic [3:0] model_rowo();
        logic [3:0] b;
        b = 4'b0001 << m_row;
        return ~b;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_row = 0; m_phase = 0; m_cnt = 0; m_col = 0;
        m_p1 = 4'hF; m_p2 = 4'hF;
        e_code = 4'h0; e_valid = 1'b0; e_down = 1'b0;
    endtask

    task automatic next_row();
        m_mode = 0; m_row = (m_row + 1) % 4; m_phase = 0;
    endtask

    task automatic accept_press();
        e_code = 4'(m_row * 4 + m_col); e_valid = 1'b1; e_down = 1'b1; m_mode = 2;
    endtask

    // cin is the column value the DUT samples at the coming rising edge.
    // Decisions use the value seen two edges earlier.
    task automatic model_step(input logic [3:0] cin);
        logic [3:0] seen;
        seen = m_p2; m_p2 = m_p1; m_p1 = cin;
        e_valid = 1'b0;
        case (m_mode)
            0: begin
                if (m_phase < DW - 1) m_phase++;
                else if (seen == 4'hF) begin m_row = (m_row + 1) % 4; m_phase = 0; end
                else begin
                    m_col = lowest_zero(seen); m_cnt = 1; m_mode = 1;
                    if (m_cnt == DEB) accept_press();
                end
            end
            1: begin
                if (!seen[m_col]) begin m_cnt++; if (m_cnt == DEB) accept_press(); end
                else next_row();
            end
            2: begin
                if (seen[m_col]) begin
                    m_cnt = 1; m_mode = 3;
                    if (m_cnt == DEB) begin e_down = 1'b0; next_row(); end
                end
            end
            default: begin
                if (seen[m_col]) begin
                    m_cnt++;
                    if (m_cnt == DEB) begin e_down = 1'b0; next_row(); end
                end else m_mode = 2;
            end
        endcase
    endtask

    // Compare process: outputs are stable at the falling edge. Stimulus only
    // changes just after a rising edge, so colI is already final here.
    always @(negedge clk) begin
        if (!rst_n) model_reset();
        check("outputs", {22'd0, rowO, key_code, key_valid, key_down},
              {22'd0, model_rowo(), e_code, e_valid, e_down});
        if (key_valid) n_valid++;
        if (rst_n) model_step(colI);
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, time %0t", $time);
        $fatal(1);
    end

    task automatic after_rise(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_down_low(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            @(negedge clk);
            if (!key_down) break;
        end
        check(name, {31'd0, key_down}, 32'd0);
    endtask

    task automatic wait_valid(input string name);
        int i;
        for (i = 0; i < 80; i++) begin
            @(negedge clk);
            if (key_valid) break;
        end
        check(name, {31'd0, key_valid}, 32'd1);
    endtask

    initial begin
        int i, det, v0;
        logic [15:0] kset;
        model_reset();

        // Reset values
        @(negedge clk);
        check("rst_rowO", {28'd0, rowO}, 32'hE);
        check("rst_code", {28'd0, key_code}, 32'h0);
        check("rst_flags", {30'd0, key_valid, key_down}, 32'h0);

        // Idle scan: each row is driven for DWELL clocks
        after_rise(1);
        rst_n = 1'b1;
        repeat (4) @(posedge clk); @(negedge clk);
        check("idle_row1", {28'd0, rowO}, 32'hD);
        repeat (4) @(posedge clk); @(negedge clk);
        check("idle_row2", {28'd0, rowO}, 32'hB);
        repeat (4) @(posedge clk); @(negedge clk);
        check("idle_row3", {28'd0, rowO}, 32'h7);
        repeat (4) @(posedge clk); @(negedge clk);
        check("idle_row0", {28'd0, rowO}, 32'hE);
        check("idle_no_valid", n_valid, 0);

        // Clean press at row 2, col 1
        after_rise(1);
        keys = 16'h0200;
        v0 = n_valid; det = -1;
        for (i = 0; i < 80; i++) begin
            @(negedge clk);
            if (det < 0 && state_dbg == 2'd1) det = i;
            if (key_valid) break;
        end
        check("press_valid", {31'd0, key_valid}, 32'd1);
        check("press_latency", i - det, DEB - 1);
        check("press_code", {28'd0, key_code}, 32'h9);
        check("press_down", {31'd0, key_down}, 32'd1);
        repeat (10) @(negedge clk);
        check("held_rowO", {28'd0, rowO}, 32'hB);
        check("press_one_pulse", n_valid - v0, 1);

        // Release with one bounce: column goes 1,0,1,... key_down falls DEB+2 clocks after the last rise
        after_rise(1); keys = 16'h0000;
        after_rise(1); keys = 16'h0200;
        after_rise(1); keys = 16'h0000;
        repeat (5) @(posedge clk); @(negedge clk);
        check("rel_still_down", {31'd0, key_down}, 32'd1);
        @(negedge clk);
        check("rel_down_fell", {31'd0, key_down}, 32'd0);
        check("rel_code_kept", {28'd0, key_code}, 32'h9);

        // Press on row 0 col 3 that bounces away before DEB samples
        v0 = n_valid;
        for (i = 0; i < 40; i++) begin
            after_rise(1);
            if (rowO == 4'hE) break;
        end
        keys = 16'h0008;
        after_rise(4);
        keys = 16'h0000;
        repeat (3) @(posedge clk); @(negedge clk);
        check("bounce_next_row", {28'd0, rowO}, 32'hD);
        check("bounce_no_valid", n_valid - v0, 0);
        check("bounce_no_down", {31'd0, key_down}, 32'd0);

        // Two keys on row 1 (cols 0 and 2): col 0 wins, col 2 is ignored while held
        after_rise(1);
        keys = 16'h0050;
        wait_valid("two_valid");
        check("two_code", {28'd0, key_code}, 32'h4);
        after_rise(1);
        keys = 16'h0010;
        repeat (12) @(negedge clk);
        check("two_still_down", {31'd0, key_down}, 32'd1);
        after_rise(1);
        keys = 16'h0000;
        wait_down_low("two_release");

        // Reset while confirming a press
        after_rise(1);
        keys = 16'h0020;
        v0 = n_valid;
        for (i = 0; i < 80; i++) begin
            @(negedge clk);
            if (m_mode == 1) break;
        end
        after_rise(1);
        rst_n = 1'b0;
        #1;
        check("rstp_rowO", {28'd0, rowO}, 32'hE);
        check("rstp_flags", {30'd0, key_valid, key_down}, 32'h0);
        keys = 16'h0000;
        after_rise(2);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        check("rstp_no_valid", n_valid - v0, 0);

        // Reset while a key is held
        after_rise(1);
        keys = 16'h4000;
        wait_valid("rsth_valid");
        check("rsth_code", {28'd0, key_code}, 32'hE);
        after_rise(3);
        rst_n = 1'b0;
        #1;
        check("rsth_rowO", {28'd0, rowO}, 32'hE);
        check("rsth_out", {26'd0, key_code, key_valid, key_down}, 32'h0);
        keys = 16'h0000;
        after_rise(2);
        rst_n = 1'b1;

        // Randomized presses, bounces, multi-key and occasional resets
        for (int it = 0; it < 60; it++) begin
            kset = 16'h0001 << $urandom_range(0, 15);
            if ($urandom_range(0, 3) == 0) kset = kset | (16'h0001 << $urandom_range(0, 15));
            after_rise($urandom_range(1, 6));
            repeat ($urandom_range(1, 40)) begin
                keys = ($urandom_range(0, 9) == 0) ? 16'h0000 : kset;
                after_rise(1);
            end
            repeat ($urandom_range(0, 2)) begin
                keys = 16'h0000; after_rise(1);
                keys = kset;     after_rise(1);
            end
            keys = 16'h0000;
            if ($urandom_range(0, 9) == 0) begin
                rst_n = 1'b0;
                after_rise($urandom_range(1, 3));
                rst_n = 1'b1;
            end
            after_rise($urandom_range(DEB + 4, 40));
        end

        repeat (4) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
